// File: rtl/shift_reg_prog.sv
// shift_reg_prog: programmable-depth, stallable delay line carrying a valid
// bit alongside each data word. The output is a combinational tap into the
// stage array, so no extra output latency is added.
module shift_reg_prog #(
  parameter int D_WIDTH    = 8,
  parameter int MAX_TAPE   = 16,
  parameter int TAP_W      = 5,
  parameter int RESET_DATA = 1
) (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic [TAP_W-1:0]   i_tap,
  input  logic               i_valid,
  input  logic [D_WIDTH-1:0] i_d,
  output logic               o_valid,
  output logic [D_WIDTH-1:0] o_q,
  output logic [TAP_W-1:0]   o_tap
);

  localparam logic [TAP_W-1:0] MAX_TAP_L = TAP_W'(MAX_TAPE);
  localparam logic [TAP_W-1:0] ONE_TAP_L = TAP_W'(1);

  logic [D_WIDTH-1:0] r_d [MAX_TAPE];
  logic [MAX_TAPE-1:0] r_v;
  logic [TAP_W-1:0]   r_tap;

  logic [TAP_W-1:0]   w_tap_clamped;
  logic [D_WIDTH-1:0] w_q;
  logic               w_v;

  // Clamp the requested depth into the physical range 1..MAX_TAPE.
  always_comb begin
    w_tap_clamped = i_tap;
    if (i_tap == '0) begin
      w_tap_clamped = ONE_TAP_L;
    end else if (i_tap > MAX_TAP_L) begin
      w_tap_clamped = MAX_TAP_L;
    end
  end

  // Tap register: loads only on enabled edges so a stall freezes it too.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_tap <= ONE_TAP_L;
    end else if (i_en) begin
      r_tap <= w_tap_clamped;
    end
  end

  // Valid bits: reset and flush both clear; flush beats the shift.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_flush) begin
      r_v <= '0;
    end else if (i_en) begin
      r_v[0] <= i_valid;
      for (int k = 1; k < MAX_TAPE; k++) begin
        r_v[k] <= r_v[k-1];
      end
    end
  end

  // Data stages: cleared on reset/flush only when RESET_DATA is set,
  // otherwise they hold across reset/flush and only the valid bits drop.
  generate
    if (RESET_DATA != 0) begin : g_rst_data
      // Shift data, zeroing all stages on reset or flush.
      always_ff @(posedge i_clk) begin
        if (i_srst || i_flush) begin
          for (int k = 0; k < MAX_TAPE; k++) begin
            r_d[k] <= '0;
          end
        end else if (i_en) begin
          r_d[0] <= i_d;
          for (int k = 1; k < MAX_TAPE; k++) begin
            r_d[k] <= r_d[k-1];
          end
        end
      end
    end else begin : g_hold_data
      // Shift data; reset and flush suppress the shift but keep contents.
      always_ff @(posedge i_clk) begin
        if (!i_srst && !i_flush && i_en) begin
          r_d[0] <= i_d;
          for (int k = 1; k < MAX_TAPE; k++) begin
            r_d[k] <= r_d[k-1];
          end
        end
      end
    end
  endgenerate

  // Select stage r_tap-1; compare-based mux avoids index width games.
  always_comb begin
    w_q = '0;
    w_v = 1'b0;
    for (int k = 0; k < MAX_TAPE; k++) begin
      if (r_tap == TAP_W'(k + 1)) begin
        w_q = r_d[k];
        w_v = r_v[k];
      end
    end
  end

  assign o_q     = w_q;
  assign o_valid = w_v;
  assign o_tap   = r_tap;

endmodule

// File: tb/tb_shift_reg_prog.sv
// Directed testbench for shift_reg_prog. Two instances share stimulus:
// one clears data on reset/flush, the other only clears valid bits.
module tb_shift_reg_prog;

  logic       i_clk = 1'b0;
  logic       i_srst = 1'b0;
  logic       i_en = 1'b0;
  logic       i_flush = 1'b0;
  logic [4:0] i_tap = 5'd1;
  logic       i_valid = 1'b0;
  logic [7:0] i_d = 8'h00;
  logic       o_valid, o_valid_nr;
  logic [7:0] o_q, o_q_nr;
  logic [4:0] o_tap, o_tap_nr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  shift_reg_prog #(.D_WIDTH(8), .MAX_TAPE(16), .TAP_W(5), .RESET_DATA(1)) u_dut (
    .i_clk(i_clk), .i_srst(i_srst), .i_en(i_en), .i_flush(i_flush),
    .i_tap(i_tap), .i_valid(i_valid), .i_d(i_d),
    .o_valid(o_valid), .o_q(o_q), .o_tap(o_tap)
  );

  shift_reg_prog #(.D_WIDTH(8), .MAX_TAPE(16), .TAP_W(5), .RESET_DATA(0)) u_dut_nr (
    .i_clk(i_clk), .i_srst(i_srst), .i_en(i_en), .i_flush(i_flush),
    .i_tap(i_tap), .i_valid(i_valid), .i_d(i_d),
    .o_valid(o_valid_nr), .o_q(o_q_nr), .o_tap(o_tap_nr)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Flush with a new tap; the sample offered on the flush edge must vanish.
  task automatic flush_prep(input logic [4:0] tap, input logic [4:0] exp_tap);
    i_en = 1'b1; i_flush = 1'b1; i_tap = tap; i_valid = 1'b1; i_d = 8'h99;
    tick();
    i_flush = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL prep_valid tap=%0d got=%b exp=0", tap, o_valid);
    end
    n_checks++;
    if (o_q !== 8'h00) begin
      n_fail++; $display("FAIL prep_q tap=%0d got=%h exp=00", tap, o_q);
    end
    n_checks++;
    if (o_tap !== exp_tap) begin
      n_fail++; $display("FAIL prep_tap req=%0d got=%0d exp=%0d", tap, o_tap, exp_tap);
    end
  endtask

  task automatic test_reset();
    i_srst = 1'b0; i_en = 1'b1; i_tap = 5'd1; i_valid = 1'b1; i_d = 8'hAA;
    repeat (3) tick();
    i_srst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid);
    end
    n_checks++;
    if (o_tap !== 5'd1) begin
      n_fail++; $display("FAIL reset_tap got=%0d exp=1", o_tap);
    end
    n_checks++;
    if (o_q !== 8'h00) begin
      n_fail++; $display("FAIL reset_q got=%h exp=00", o_q);
    end
    n_checks++;
    if (o_valid_nr !== 1'b0 || o_q_nr !== 8'hAA) begin
      n_fail++; $display("FAIL reset_nodata got v=%b q=%h exp v=0 q=aa", o_valid_nr, o_q_nr);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q;
    logic       exp_v;
    i_srst = 1'b0; i_tap = 5'd4; i_en = 1'b1; i_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      i_d = 8'(i);
      tick();
      exp_v = (i >= 4);
      exp_q = (i >= 4) ? 8'(i - 3) : 8'h00;
      n_checks++;
      if (o_tap !== 5'd4 || o_valid !== exp_v || o_q !== exp_q) begin
        n_fail++;
        $display("FAIL basic step=%0d got tap=%0d v=%b q=%h exp tap=4 v=%b q=%h",
                 i, o_tap, o_valid, o_q, exp_v, exp_q);
      end
    end
  endtask

  // Flush to a known state at the requested depth, then stream and check delay.
  task automatic test_depth(input logic [4:0] tap, input int depth, input int base);
    logic [7:0] exp_q;
    logic       exp_v;
    flush_prep(tap, 5'(depth));
    for (int i = 0; i < depth + 3; i++) begin
      i_d = 8'(base + i); i_valid = 1'b1;
      tick();
      exp_v = (i >= depth - 1);
      exp_q = (i >= depth - 1) ? 8'(base + i - (depth - 1)) : 8'h00;
      n_checks++;
      if (o_valid !== exp_v || o_q !== exp_q) begin
        n_fail++;
        $display("FAIL depth req=%0d step=%0d got v=%b q=%h exp v=%b q=%h",
                 tap, i, o_valid, o_q, exp_v, exp_q);
      end
    end
  endtask

  task automatic test_stall();
    int j;
    logic [7:0] exp_q;
    logic       exp_v;
    flush_prep(5'd3, 5'd3);
    j = 0;
    for (int s = 0; s < 21; s++) begin
      if (s >= 6 && s < 11) begin
        i_en = 1'b0; i_tap = 5'd7; i_valid = 1'b1; i_d = 8'hEE;
      end else begin
        i_en = 1'b1; i_tap = 5'd3; i_valid = 1'b1; i_d = 8'(8'h10 + j);
        j++;
      end
      tick();
      exp_v = (j >= 3);
      exp_q = (j >= 3) ? 8'(8'h10 + j - 3) : 8'h00;
      n_checks++;
      if (o_tap !== 5'd3 || o_valid !== exp_v || o_q !== exp_q) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got tap=%0d v=%b q=%h exp tap=3 v=%b q=%h",
                 s, o_tap, o_valid, o_q, exp_v, exp_q);
      end
    end
    i_en = 1'b1;
  endtask

  task automatic test_flush();
    logic [7:0] exp_q;
    logic       exp_v;
    flush_prep(5'd8, 5'd8);
    for (int i = 0; i < 8; i++) begin
      i_d = 8'(8'h21 + i); i_valid = 1'b1;
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b1 || o_q !== 8'h21) begin
      n_fail++; $display("FAIL flush_fill got v=%b q=%h exp v=1 q=21", o_valid, o_q);
    end
    i_flush = 1'b1; i_d = 8'h99; i_valid = 1'b1;
    tick();
    i_flush = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_q !== 8'h00) begin
      n_fail++; $display("FAIL flush_clear got v=%b q=%h exp v=0 q=00", o_valid, o_q);
    end
    n_checks++;
    if (o_valid_nr !== 1'b0 || o_q_nr !== 8'h21) begin
      n_fail++; $display("FAIL flush_hold got v=%b q=%h exp v=0 q=21", o_valid_nr, o_q_nr);
    end
    for (int i = 0; i < 8; i++) begin
      i_d = 8'(8'h31 + i); i_valid = 1'b1;
      tick();
      exp_v = (i == 7);
      exp_q = (i == 7) ? 8'h31 : 8'h00;
      n_checks++;
      if (o_valid !== exp_v || o_q !== exp_q || o_valid_nr !== exp_v) begin
        n_fail++;
        $display("FAIL flush_gap step=%0d got v=%b q=%h vnr=%b exp v=%b q=%h",
                 i, o_valid, o_q, o_valid_nr, exp_v, exp_q);
      end
    end
  endtask

  task automatic test_tap_change();
    int t;
    logic [7:0] exp_q;
    logic       exp_v;
    flush_prep(5'd6, 5'd6);
    for (int i = 0; i < 16; i++) begin
      t = (i >= 10 && i < 12) ? 2 : 6;
      i_tap = 5'(t); i_d = 8'(8'h40 + i); i_valid = 1'b1;
      tick();
      exp_v = (i >= t - 1);
      exp_q = (i >= t - 1) ? 8'(8'h40 + i - (t - 1)) : 8'h00;
      n_checks++;
      if (o_tap !== 5'(t) || o_valid !== exp_v || o_q !== exp_q) begin
        n_fail++;
        $display("FAIL tap_change step=%0d got tap=%0d v=%b q=%h exp tap=%0d v=%b q=%h",
                 i, o_tap, o_valid, o_q, t, exp_v, exp_q);
      end
    end
  endtask

  task automatic test_priority();
    flush_prep(5'd5, 5'd5);
    for (int i = 0; i < 6; i++) begin
      i_d = 8'(8'h60 + i); i_valid = 1'b1;
      tick();
    end
    i_srst = 1'b1; i_flush = 1'b1; i_en = 1'b1; i_tap = 5'd9;
    tick();
    i_srst = 1'b0; i_flush = 1'b0;
    n_checks++;
    if (o_tap !== 5'd1 || o_valid !== 1'b0 || o_q !== 8'h00) begin
      n_fail++;
      $display("FAIL priority got tap=%0d v=%b q=%h exp tap=1 v=0 q=00", o_tap, o_valid, o_q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_depth(5'd0, 1, 8'h80);
    test_depth(5'd31, 16, 8'h50);
    test_depth(5'd16, 16, 8'hA0);
    test_stall();
    test_flush();
    test_tap_change();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
